// File: rtl/tbuf_bus_arbiter.sv
// rtl/tbuf_bus_arbiter.sv - round-robin tri-state bus arbiter with break-before-make turnaround
module tbuf_bus_arbiter #(
   parameter int N        = 4,
   parameter int DEAD     = 1,
   parameter int MAX_HOLD = 16,
   localparam int GW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic          CLK,
   input  logic          R,
   input  logic [N-1:0]  REQ,
   output logic [N-1:0]  EN,
   output logic [N-1:0]  EN_BAR,
   output logic [GW-1:0] GNT_ID,
   output logic          BUSY,
   output logic          TIMEOUT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_TURN
   } state_t;

   state_t        state;
   logic [GW-1:0] ptr;
   logic [7:0]    hold_cnt;
   logic [3:0]    dead_cnt;

   logic [GW-1:0] pick;
   logic          pick_vld;
   logic [GW-1:0] wrap_pick;
   logic          wrap_vld;
   logic [N-1:0]  grant_vec;
   logic [GW-1:0] ptr_nxt;
   logic          own_req;
   logic          hold_limit;

   // Round-robin pick: lowest requester at or above ptr, else lowest requester overall.
   always_comb begin
      pick      = '0;
      pick_vld  = 1'b0;
      wrap_pick = '0;
      wrap_vld  = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (REQ[j]) begin
            wrap_pick = j[GW-1:0];
            wrap_vld  = 1'b1;
            if (j >= int'(ptr)) begin
               pick     = j[GW-1:0];
               pick_vld = 1'b1;
            end
         end
      end
      if (!pick_vld) begin
         pick     = wrap_pick;
         pick_vld = wrap_vld;
      end
   end

   // Derived decode: one-hot of the pick, next pointer after the owner, and exit conditions.
   always_comb begin
      grant_vec  = N'(1) << pick;
      ptr_nxt    = '0;
      if (int'(GNT_ID) < N - 1) begin
         ptr_nxt = GNT_ID + 1'b1;
      end
      // EN is one-hot on the owner while granting, so this is the owner's own request.
      own_req    = |(REQ & EN);
      hold_limit = (MAX_HOLD != 0) && (hold_cnt >= 8'(MAX_HOLD));
   end

   // Sequencer: IDLE arbitrates, GRANT holds the owner, TURN keeps every driver off for DEAD cycles.
   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         state    <= S_IDLE;
         ptr      <= '0;
         hold_cnt <= 8'd0;
         dead_cnt <= 4'd0;
         EN       <= '0;
         EN_BAR   <= '1;
         GNT_ID   <= '0;
         BUSY     <= 1'b0;
         TIMEOUT  <= 1'b0;
      end else begin
         TIMEOUT <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  state    <= S_GRANT;
                  EN       <= grant_vec;
                  EN_BAR   <= ~grant_vec;
                  GNT_ID   <= pick;
                  BUSY     <= 1'b1;
                  hold_cnt <= 8'd1;
               end
            end
            S_GRANT: begin
               if (own_req && !hold_limit) begin
                  // Saturate rather than wrap so an unlimited hold never looks like a fresh grant.
                  if (hold_cnt != 8'hFF) begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end else begin
                  state    <= S_TURN;
                  EN       <= '0;
                  EN_BAR   <= '1;
                  GNT_ID   <= '0;
                  BUSY     <= 1'b0;
                  dead_cnt <= 4'(DEAD);
                  TIMEOUT  <= own_req;
                  ptr      <= ptr_nxt;
               end
            end
            S_TURN: begin
               if (dead_cnt <= 4'd1) begin
                  state <= S_IDLE;
               end else begin
                  dead_cnt <= dead_cnt - 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// tb/tb_tbuf_bus_arbiter.sv - self-checking bench for tbuf_bus_arbiter
module tb_tbuf_bus_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req_a, req_b;
   logic [2:0] req_c;
   logic [3:0] en_a, enb_a, en_b, enb_b;
   logic [2:0] en_c, enb_c;
   logic [1:0] gnt_a, gnt_b, gnt_c;
   logic       busy_a, busy_b, busy_c;
   logic       tmo_a, tmo_b, tmo_c;

   int n_vec = 0;
   int n_err = 0;

   tbuf_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(16)) u_a (
      .CLK(clk), .R(rst), .REQ(req_a), .EN(en_a), .EN_BAR(enb_a),
      .GNT_ID(gnt_a), .BUSY(busy_a), .TIMEOUT(tmo_a));

   tbuf_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(4)) u_b (
      .CLK(clk), .R(rst), .REQ(req_b), .EN(en_b), .EN_BAR(enb_b),
      .GNT_ID(gnt_b), .BUSY(busy_b), .TIMEOUT(tmo_b));

   tbuf_bus_arbiter #(.N(3), .DEAD(2), .MAX_HOLD(0)) u_c (
      .CLK(clk), .R(rst), .REQ(req_c), .EN(en_c), .EN_BAR(enb_c),
      .GNT_ID(gnt_c), .BUSY(busy_c), .TIMEOUT(tmo_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the bus, how long, how many quiet cycles since the last owner.
   typedef struct {
      int owner;
      int held;
      int idle;
      int ptr;
      bit tmo;
   } mdl_t;

   mdl_t ma, mb, mc;

   logic [15:0] last_nz [3];
   int          zrun    [3];

   typedef struct {
      int         inst;
      logic [3:0] req;
      logic [3:0] en;
      int         gnt;
      logic       tmo;
   } vec_t;

   vec_t tbl[$];

   function automatic mdl_t mreset(input int dead);
      mdl_t r;
      r.owner = -1;
      r.held  = 0;
      r.idle  = dead + 1;
      r.ptr   = 0;
      r.tmo   = 1'b0;
      return r;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int n, input int dead, input int maxh,
                                 input logic [15:0] req_raw);
      mdl_t        r;
      logic [15:0] req;
      r     = m;
      req   = req_raw & ((16'd1 << n) - 16'd1);
      r.tmo = 1'b0;
      if (m.owner >= 0) begin
         if (req[4'(m.owner)] && (maxh == 0 || m.held < maxh)) begin
            r.held = (m.held < 255) ? m.held + 1 : 255;
         end else begin
            r.tmo   = req[4'(m.owner)];
            r.ptr   = (m.owner + 1) % n;
            r.owner = -1;
            r.idle  = 1;
         end
      end else if (m.idle > dead && req != 16'd0) begin
         for (int i = n - 1; i >= 0; i--) begin
            if (req[4'((m.ptr + i) % n)]) r.owner = (m.ptr + i) % n;
         end
         r.held = 1;
      end else begin
         r.idle = (m.idle < 1000) ? m.idle + 1 : 1000;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_inst(input string nm, input int idx, input int n, input int dead,
                             input mdl_t m, input logic [15:0] en, input logic [15:0] enb,
                             input logic [31:0] gnt, input logic busy, input logic tmo);
      logic [15:0] mask;
      logic [15:0] exp_en;
      mask   = (16'd1 << n) - 16'd1;
      exp_en = (m.owner >= 0) ? (16'd1 << m.owner) : 16'd0;
      chk({nm, ".en"}, 32'(en), 32'(exp_en));
      chk({nm, ".timeout"}, 32'(tmo), 32'(m.tmo));
      chk({nm, ".busy_or"}, 32'(busy), 32'(|en));
      chk({nm, ".en_bar"}, 32'(enb), 32'(~en & mask));
      chk({nm, ".onehot"}, 32'($countones(en) <= 1), 32'd1);
      chk({nm, ".gnt_range"}, 32'(gnt < 32'(n)), 32'd1);
      if (busy === 1'b1) chk({nm, ".gnt"}, gnt, 32'(m.owner));
      if (en != 16'd0) begin
         if (last_nz[idx] != 16'd0 && en != last_nz[idx])
            chk({nm, ".dead_gap"}, 32'(zrun[idx] >= dead + 1), 32'd1);
         last_nz[idx] = en;
         zrun[idx]    = 0;
      end else begin
         zrun[idx]++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         ma = mreset(1);
         mb = mreset(1);
         mc = mreset(2);
         for (int i = 0; i < 3; i++) begin
            last_nz[i] = 16'd0;
            zrun[i]    = 0;
         end
      end else begin
         ma = step(ma, 4, 1, 16, 16'(req_a));
         mb = step(mb, 4, 1, 4, 16'(req_b));
         mc = step(mc, 3, 2, 0, 16'(req_c));
      end
      @(negedge clk);
      check_inst("a", 0, 4, 1, ma, 16'(en_a), 16'(enb_a), 32'(gnt_a), busy_a, tmo_a);
      check_inst("b", 1, 4, 1, mb, 16'(en_b), 16'(enb_b), 32'(gnt_b), busy_b, tmo_b);
      check_inst("c", 2, 3, 2, mc, 16'(en_c), 16'(enb_c), 32'(gnt_c), busy_c, tmo_c);
   endtask

   task automatic add(input int inst, input logic [3:0] req, input logic [3:0] en, input int gnt);
      vec_t v;
      v.inst = inst;
      v.req  = req;
      v.en   = en;
      v.gnt  = gnt;
      v.tmo  = 1'b0;
      tbl.push_back(v);
   endtask

   initial begin
      ma = mreset(1);
      mb = mreset(1);
      mc = mreset(2);
      for (int i = 0; i < 3; i++) begin
         last_nz[i] = 16'd0;
         zrun[i]    = 0;
      end

      // Reset held with every request active.
      rst   = 1'b1;
      req_a = 4'b1111;
      req_b = 4'b1111;
      req_c = 3'b111;
      for (int i = 0; i < 3; i++) tick();
      chk("rst.en", 32'(en_a), 32'd0);
      chk("rst.en_bar", 32'(enb_a), 32'hF);
      chk("rst.busy", 32'(busy_a), 32'd0);
      chk("rst.gnt", 32'(gnt_a), 32'd0);
      chk("rst.timeout", 32'(tmo_a), 32'd0);
      req_a = 4'b0000;
      req_b = 4'b0000;
      req_c = 3'b000;
      rst   = 1'b0;
      tick();

      // Single request, reassignment on drop, pointer wrap on N=3, owner-swap with TURN activity.
      for (int i = 0; i < 5; i++) add(0, 4'b0010, 4'b0010, 1);
      for (int i = 0; i < 3; i++) add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1000, 4'b1000, 3);
      add(0, 4'b1001, 4'b1000, 3);
      add(0, 4'b0001, 4'b0000, 0);
      add(0, 4'b0001, 4'b0000, 0);
      add(0, 4'b0001, 4'b0001, 0);
      add(0, 4'b0000, 4'b0000, 0);
      add(2, 4'b0010, 4'b0010, 1);
      add(2, 4'b0000, 4'b0000, 0);
      add(2, 4'b0011, 4'b0000, 0);
      add(2, 4'b0011, 4'b0000, 0);
      add(2, 4'b0011, 4'b0001, 0);
      add(2, 4'b0010, 4'b0000, 0);
      add(2, 4'b0010, 4'b0000, 0);
      add(2, 4'b0010, 4'b0000, 0);
      add(2, 4'b0010, 4'b0010, 1);
      add(2, 4'b0000, 4'b0000, 0);
      add(2, 4'b0000, 4'b0000, 0);
      add(2, 4'b0000, 4'b0000, 0);
      add(2, 4'b0001, 4'b0001, 0);
      add(2, 4'b0001, 4'b0001, 0);
      add(2, 4'b0010, 4'b0000, 0);
      add(2, 4'b0000, 4'b0000, 0);
      add(2, 4'b0010, 4'b0000, 0);
      add(2, 4'b0010, 4'b0010, 1);
      add(2, 4'b0000, 4'b0000, 0);

      foreach (tbl[i]) begin
         logic [3:0] act_en;
         logic [1:0] act_gnt;
         logic       act_tmo;
         if (tbl[i].inst == 0) req_a = tbl[i].req;
         else req_c = tbl[i].req[2:0];
         tick();
         act_en  = (tbl[i].inst == 0) ? en_a  : {1'b0, en_c};
         act_gnt = (tbl[i].inst == 0) ? gnt_a : gnt_c;
         act_tmo = (tbl[i].inst == 0) ? tmo_a : tmo_c;
         chk($sformatf("vec%0d.en", i), 32'(act_en), 32'(tbl[i].en));
         chk($sformatf("vec%0d.timeout", i), 32'(act_tmo), 32'(tbl[i].tmo));
         if (tbl[i].en != 4'b0000)
            chk($sformatf("vec%0d.gnt", i), 32'(act_gnt), 32'(tbl[i].gnt));
      end

      // Rotation under constant demand with MAX_HOLD=4: 0,1,2,3,0.
      for (int i = 0; i < 4; i++) tick();
      req_b = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk("rot.en", 32'(en_b), 32'd1 << (g % 4));
            chk("rot.gnt", 32'(gnt_b), 32'(g % 4));
            chk("rot.timeout_low", 32'(tmo_b), 32'd0);
         end
         tick();
         chk("rot.gap1_en", 32'(en_b), 32'd0);
         chk("rot.gap1_timeout", 32'(tmo_b), 32'd1);
         tick();
         chk("rot.gap2_en", 32'(en_b), 32'd0);
         chk("rot.gap2_timeout", 32'(tmo_b), 32'd0);
      end
      req_b = 4'b0000;

      // Unlimited hold: one continuous grant well past the 8-bit counter range.
      for (int i = 0; i < 4; i++) tick();
      req_c = 3'b100;
      for (int i = 0; i < 300; i++) begin
         tick();
         chk("hold.en", 32'(en_c), 32'h4);
         chk("hold.timeout", 32'(tmo_c), 32'd0);
      end
      req_c = 3'b000;
      tick();
      chk("hold.release", 32'(en_c), 32'd0);

      // Asynchronous reset in the middle of a grant.
      for (int i = 0; i < 4; i++) tick();
      req_a = 4'b0001;
      tick();
      tick();
      chk("arst.pre_en", 32'(en_a), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("arst.en", 32'(en_a), 32'd0);
      chk("arst.en_bar", 32'(enb_a), 32'hF);
      chk("arst.busy", 32'(busy_a), 32'd0);
      tick();
      rst   = 1'b0;
      req_a = 4'b0000;
      tick();

      // Randomized traffic on all three instances against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) req_a = 4'($urandom);
         if ($urandom_range(3) == 0) req_b = 4'($urandom);
         if ($urandom_range(3) == 0) req_c = 3'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
